// File: rtl/and16_operand_pipe.sv
//------------------------------------------------------------------------------
// Module      : and16_operand_pipe (with leaf and16)
// Description : FIFO-buffered valid/ready front end for an And16 gate, with a
//               registered result port and a delivered-result counter.
//               Optional NAND select: define AND16_OPERAND_PIPE_NAND_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module and16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign y[gi] = a[gi] & b[gi];
        end
    endgenerate
endmodule

module and16_operand_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [15:0]      op_count
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
`ifdef AND16_OPERAND_PIPE_NAND_EN
    localparam int ENTRY_W = 2 * WIDTH + 1;
`else
    localparam int ENTRY_W = 2 * WIDTH;
`endif

    generate
        if (WIDTH != 16) begin : g_bad_width
            $error("and16_operand_pipe: WIDTH must be 16");
        end
        if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
            $error("and16_operand_pipe: DEPTH must be 2, 4 or 8");
        end
    endgenerate

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [15:0]        op_count_q, op_count_d;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_out_xfer;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic [WIDTH-1:0]   w_and;
    logic [WIDTH-1:0]   w_result;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign w_out_xfer = out_valid_q && out_ready;
    assign w_pop      = !w_empty && (!out_valid_q || out_ready);

    assign w_head   = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign w_head_a = w_head[2*WIDTH-1:WIDTH];
    assign w_head_b = w_head[WIDTH-1:0];

    and16 u_and16 (
        .a (w_head_a),
        .b (w_head_b),
        .y (w_and)
    );

`ifdef AND16_OPERAND_PIPE_NAND_EN
    assign w_wr_entry = {op, in1, in2};
    assign w_result   = w_head[2*WIDTH] ? ~w_and : w_and;
`else
    logic w_unused_op;
    assign w_unused_op = op;
    assign w_wr_entry  = {in1, in2};
    assign w_result    = w_and;
`endif

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = w_wr_entry;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // A pop refills the result register in the same edge it is drained.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        if (w_pop) begin
            out_d       = w_result;
            out_valid_d = 1'b1;
        end else if (w_out_xfer) begin
            out_valid_d = 1'b0;
        end
        if (w_out_xfer) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            op_count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            op_count_q  <= op_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_and16_operand_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_and16_operand_pipe
// Description : Directed self-checking bench for and16_operand_pipe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_and16_operand_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in1 = 16'h0;
    logic [15:0] in2 = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out;
    logic [15:0] op_count;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_cnt = 16'h0;
    bit          stream_mon = 1'b0;
    int          gaps = 0;
    logic [15:0] held;

    and16_operand_pipe #(.DEPTH(2), .WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic o);
`ifdef AND16_OPERAND_PIPE_NAND_EN
        return o ? ~(a & b) : (a & b);
`else
        return a & b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score the output handshake, then the input handshake, then advance.
    task automatic tick();
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {15'd0, out_valid}, 16'd0);
            end else begin
                chk("sb_data", out, exp_q.pop_front());
                model_cnt = model_cnt + 16'd1;
            end
        end
        if (in_valid && in_ready === 1'b1) exp_q.push_back(model(in1, in2, op));
        if (stream_mon && exp_q.size() > 0 && out_valid !== 1'b1) gaps++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic o);
        int n;
        in1 = a; in2 = b; op = o; in_valid = 1'b1; n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("send_timeout", {15'd0, in_ready}, 16'd1);
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        logic [15:0] nand_exp;
        @(negedge clk);
        // Reset
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out", out, 16'h0000);
        chk("rst_op_count", op_count, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);

        // Single pair latency
        out_ready = 1'b1;
        in1 = 16'hF0F0; in2 = 16'hFF00; op = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_edge_n_valid", {15'd0, out_valid}, 16'd0);
        tick();
        chk("lat_edge_n1_valid", {15'd0, out_valid}, 16'd1);
        chk("lat_edge_n1_out", out, 16'hF000);
        tick();
        chk("single_op_count", op_count, 16'd1);

        // Stall with DEPTH=2
        out_ready = 1'b0;
        send(16'h1234, 16'hFF0F, 1'b0);
        send(16'hABCD, 16'h0FF0, 1'b0);
        send(16'h5A5A, 16'hFFFF, 1'b0);
        chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
        chk("stall_out_valid", {15'd0, out_valid}, 16'd1);
        chk("stall_out_first", out, 16'h1204);
        held = out;
        tick(); tick();
        chk("stall_out_hold", out, held);
        chk("stall_in_ready_hold", {15'd0, in_ready}, 16'd0);
        out_ready = 1'b1;
        tick();
        chk("stall_ready_back", {15'd0, in_ready}, 16'd1);
        drain();
        chk("stall_op_count", op_count, model_cnt);
        chk("stall_op_count_abs", op_count, 16'd4);

        // Streaming
        for (int i = 0; i < 10; i++) begin
            if (i == 2) stream_mon = 1'b1;
            send(16'(i), 16'h5555, 1'b0);
        end
        drain();
        stream_mon = 1'b0;
        chk("stream_gaps", 16'(gaps), 16'd0);
        chk("stream_op_count", op_count, 16'd14);

        // Reset mid-stream
        out_ready = 1'b0;
        send(16'h1111, 16'hFFFF, 1'b0);
        send(16'h2222, 16'hFFFF, 1'b0);
        send(16'h3333, 16'hFFFF, 1'b0);
        chk("mid_full", {15'd0, in_ready}, 16'd0);
        chk("mid_valid", {15'd0, out_valid}, 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        model_cnt = 16'h0;
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_out", out, 16'h0000);
        chk("mid_rst_op_count", op_count, 16'h0000);
        chk("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("mid_no_stale", {15'd0, out_valid}, 16'd0);

        // AND / NAND select
`ifdef AND16_OPERAND_PIPE_NAND_EN
        nand_exp = 16'hFF00;
`else
        nand_exp = 16'h00FF;
`endif
        send(16'hFFFF, 16'h00FF, 1'b1);
        tick();
        chk("op1_out", out, nand_exp);
        send(16'hFFFF, 16'h00FF, 1'b0);
        tick();
        chk("op0_out", out, 16'h00FF);
        drain();

        // op_count wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        model_cnt = 16'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            send(16'(i), ~16'(i * 3), 1'b0);
        end
        drain();
        chk("wrap_preload", op_count, 16'hFFFF);
        send(16'hBEEF, 16'hF00F, 1'b0);
        drain();
        chk("wrap_zero", op_count, 16'h0000);
        chk("wrap_model", op_count, model_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
